// File: rtl/frec_seq.sv
// frec_seq -- table-driven frequency sequencer.
//
// Holds a 4-entry table of {divide, repeat} pairs. When started, it walks the
// table from the lowest entry with a nonzero repeat count. For each entry it
// emits REP periods of o_clk2, where each period is 2*D input clocks and
// D = DIV (D = 1 when DIV = 0). Entries with REP = 0 are skipped. With
// i_loop = 1 the walk wraps from entry 3 back to entry 0.
//
// Ports:
//   i_clk    : clock; all state changes on its rising edge
//   i_rst_n  : asynchronous active-low reset; also clears the table
//   i_we     : table write strobe; ignored while o_busy = 1
//   i_addr   : table entry index for writes
//   i_wdiv   : divide value written to entry i_addr
//   i_wrep   : repeat count written to entry i_addr
//   i_start  : start the sequence (IDLE only)
//   i_stop   : abort the sequence; wins over start and over completion
//   i_loop   : 1 = wrap from entry 3 to entry 0, 0 = finish after entry 3
//   o_clk2   : divided output clock, registered
//   o_idx    : index of the active entry
//   o_busy   : high while running
//   o_done   : one-cycle pulse on sequence completion
module frec_seq #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [1:0]    i_addr,
    input  logic [DW-1:0] i_wdiv,
    input  logic [RW-1:0] i_wrep,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_loop,
    output logic          o_clk2,
    output logic [1:0]    o_idx,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_div [4];
    logic [RW-1:0] r_rep [4];
    logic [DW-1:0] r_cnt;
    logic [RW-1:0] r_per;
    logic          r_clk2;
    logic [1:0]    r_idx;

    logic [DW-1:0] w_dlim;
    logic [RW-1:0] w_per_inc;
    logic          w_tick;
    logic          w_fall;
    logic          w_entry_done;
    logic          w_any;
    logic [1:0]    w_first;
    logic          w_has_next;
    logic [1:0]    w_next;
    logic [1:0]    w_cand;

    // Terminal count of the divider: D-1, with DIV = 0 treated as D = 1.
    assign w_dlim       = (r_div[r_idx] == '0) ? '0 : r_div[r_idx] - 1'b1;
    assign w_tick       = (r_cnt == w_dlim);
    assign w_fall       = w_tick && r_clk2;
    assign w_per_inc    = r_per + 1'b1;
    assign w_entry_done = w_fall && (w_per_inc == r_rep[r_idx]);

    // Lowest entry with a nonzero repeat count.
    always_comb begin
        w_any   = 1'b0;
        w_first = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!w_any && r_rep[k] != '0) begin
                w_any   = 1'b1;
                w_first = 2'(k);
            end
        end
    end

    // Next active entry after r_idx, searched in wrap order idx+1, idx+2,
    // idx+3, idx. Candidates at or below r_idx have wrapped past entry 3 and
    // are only eligible with i_loop set, so i_loop is sampled at each decision.
    always_comb begin
        w_has_next = 1'b0;
        w_next     = '0;
        w_cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_cand = r_idx + 2'(k);
            if (!w_has_next && r_rep[w_cand] != '0 &&
                ((w_cand > r_idx) || i_loop)) begin
                w_has_next = 1'b1;
                w_next     = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nxt = w_any ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_entry_done && !w_has_next) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < 4; k++) begin
                r_div[k] <= '0;
                r_rep[k] <= '0;
            end
            r_cnt  <= '0;
            r_per  <= '0;
            r_clk2 <= 1'b0;
            r_idx  <= '0;
        end else begin
            if (i_we && r_state != S_RUN) begin
                r_div[i_addr] <= i_wdiv;
                r_rep[i_addr] <= i_wrep;
            end
            if (r_state == S_RUN) begin
                if (i_stop) begin
                    r_cnt  <= '0;
                    r_per  <= '0;
                    r_clk2 <= 1'b0;
                end else if (w_tick) begin
                    r_cnt  <= '0;
                    r_clk2 <= ~r_clk2;
                    // Entry switches happen only on the falling toggle, so the
                    // new ratio always starts from o_clk2 = 0.
                    if (w_fall) begin
                        if (w_entry_done) begin
                            r_per <= '0;
                            if (w_has_next) begin
                                r_idx <= w_next;
                            end
                        end else begin
                            r_per <= w_per_inc;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt  <= '0;
                r_per  <= '0;
                r_clk2 <= 1'b0;
                if (r_state == S_IDLE && i_start && !i_stop) begin
                    r_idx <= w_first;
                end
            end
        end
    end

    assign o_clk2 = r_clk2;
    assign o_idx  = r_idx;
    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_FIN);

endmodule

// File: tb/tb_frec_seq.sv
// Testbench for frec_seq. Expected output tuples {clk2, idx, busy, done} are
// pushed into a queue when a sequence is launched and popped one per clock,
// sampled 1 time unit after the rising edge.
module tb_frec_seq;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    addr = '0;
    logic [DW-1:0] wdiv = '0;
    logic [RW-1:0] wrep = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          clk2;
    logic [1:0]    idx;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Shadow of the table contents as the bench believes they should be.
    int m_div [4];
    int m_rep [4];

    logic [4:0] q [$];

    frec_seq #(.DW(DW), .RW(RW)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdiv  (wdiv),
        .i_wrep  (wrep),
        .i_start (start),
        .i_stop  (stop),
        .i_loop  (loop_en),
        .o_clk2  (clk2),
        .o_idx   (idx),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] mk(input logic c, input int i, input logic b, input logic d);
        return {c, 2'(i), b, d};
    endfunction

    task automatic chk(input string tag, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got clk2/idx/busy/done=%b/%0d/%b/%b want %b/%0d/%b/%b at %0t",
                     tag, act[4], act[3:2], act[1], act[0], exp[4], exp[3:2], exp[1], exp[0], $time);
        end
    endtask

    task automatic wr(input int a, input int d, input int r);
        addr = 2'(a);
        wdiv = DW'(d);
        wrep = RW'(r);
        we   = 1'b1;
        @(posedge clk); #1;
        we   = 1'b0;
        m_div[a] = d;
        m_rep[a] = r;
    endtask

    task automatic wr_all(input int d0, input int r0, input int d1, input int r1,
                          input int d2, input int r2, input int d3, input int r3);
        wr(0, d0, r0); wr(1, d1, r1); wr(2, d2, r2); wr(3, d3, r3);
    endtask

    // Expand the shadow table into the expected per-cycle waveform: each
    // period is D samples low then D samples high; entries walked in index
    // order 'passes' times; optionally followed by one FIN and one IDLE sample.
    task automatic push_run(input int passes, input bit fin);
        int d;
        int last;
        last = 0;
        for (int p = 0; p < passes; p++) begin
            for (int e = 0; e < 4; e++) begin
                if (m_rep[e] != 0) begin
                    d = (m_div[e] == 0) ? 1 : m_div[e];
                    last = e;
                    for (int r = 0; r < m_rep[e]; r++) begin
                        repeat (d) q.push_back(mk(1'b0, e, 1'b1, 1'b0));
                        repeat (d) q.push_back(mk(1'b1, e, 1'b1, 1'b0));
                    end
                end
            end
        end
        if (fin) begin
            q.push_back(mk(1'b0, last, 1'b0, 1'b1));
            q.push_back(mk(1'b0, last, 1'b0, 1'b0));
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [4:0] e;
        @(posedge clk); #1;
        e = q.pop_front();
        chk(tag, {clk2, idx, busy, done}, e);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n && q.size() > 0; i++) pop_chk(tag);
    endtask

    // Pulse start for the launching edge and check its sample.
    task automatic run_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(tag, {clk2, idx, busy, done}, q.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin m_div[i] = 0; m_rep[i] = 0; end
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset", {clk2, idx, busy, done}, mk(1'b0, 0, 1'b0, 1'b0));

        // Start together with stop does not launch.
        start = 1'b1; stop = 1'b1;
        q.push_back(mk(1'b0, 0, 1'b0, 1'b0));
        pop_chk("start_stop");
        start = 1'b0; stop = 1'b0;

        // All repeat counts zero: immediate DONE, no clk2 edge.
        push_run(1, 1'b1);
        run_start("allzero");
        drain("allzero", q.size());

        // Single entry {3,2}.
        wr_all(3, 2, 0, 0, 0, 0, 0, 0);
        loop_en = 1'b0;
        push_run(1, 1'b1);
        run_start("e0_3x2");
        drain("e0_3x2", q.size());

        // Skip a zero-repeat entry and switch ratio on a low phase.
        wr_all(2, 1, 0, 0, 5, 1, 1, 0);
        push_run(1, 1'b1);
        run_start("skip");
        drain("skip", q.size());

        // Loop on one entry for 10 periods, then stop.
        wr_all(1, 1, 0, 0, 0, 0, 0, 0);
        loop_en = 1'b1;
        push_run(10, 1'b0);
        run_start("loop");
        drain("loop", q.size());
        stop = 1'b1;
        q.push_back(mk(1'b0, 0, 1'b0, 1'b0));
        pop_chk("stop");
        stop = 1'b0;
        q.push_back(mk(1'b0, 0, 1'b0, 1'b0));
        pop_chk("stop_nodone");

        // Clearing loop mid-run ends the sequence after entry 3.
        wr_all(1, 1, 0, 0, 0, 0, 2, 1);
        loop_en = 1'b1;
        push_run(2, 1'b1);
        run_start("loopclr");
        fork
            drain("loopclr", q.size());
            begin
                repeat (6) @(posedge clk);
                #1 loop_en = 1'b0;
            end
        join

        // Writes and start during a run are ignored.
        wr_all(3, 1, 0, 0, 0, 0, 0, 0);
        push_run(1, 1'b1);
        run_start("we_run");
        fork
            drain("we_run", q.size());
            begin
                repeat (2) @(posedge clk);
                #1;
                addr = 2'd0; wdiv = DW'(7); wrep = RW'(5); we = 1'b1; start = 1'b1;
                @(posedge clk); #1;
                we = 1'b0; start = 1'b0;
            end
        join
        push_run(1, 1'b1);
        run_start("we_after");
        drain("we_after", q.size());

        // Asynchronous reset mid-period with clk2 high.
        wr_all(0, 0, 0, 0, 4, 3, 0, 0);
        push_run(1, 1'b1);
        run_start("pre_rst");
        drain("pre_rst", 5);
        q.delete();
        chk("pre_rst_hi", {clk2, idx, busy, done}, mk(1'b1, 2, 1'b1, 1'b0));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {clk2, idx, busy, done}, mk(1'b0, 0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin m_div[i] = 0; m_rep[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold", {clk2, idx, busy, done}, mk(1'b0, 0, 1'b0, 1'b0));
        push_run(1, 1'b1);
        run_start("rst_zero");
        drain("rst_zero", q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
